// File: rtl/twos_comp_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// twos_comp_share_ctrl_if
// Request/result bus of the shared two's-complement negation block.
//   REQ_VALID/REQ_READY/REQ_A/REQ_BYPASS : per-requester operand handshake
//   OUT_VALID/OUT_READY/OUT_S/OUT_ID     : single tagged result port
//   BUSY                                 : any pipeline stage occupied
// master = requesters + result consumer, slave = the controller.
// ---------------------------------------------------------------------------
interface twos_comp_share_ctrl_if #(
    parameter int C_WIDTH    = 16,
    parameter int C_NUM_REQ  = 4,
    parameter int C_ID_WIDTH = 2
);
    logic [C_NUM_REQ-1:0]         REQ_VALID;
    logic [C_NUM_REQ-1:0]         REQ_READY;
    logic [C_NUM_REQ*C_WIDTH-1:0] REQ_A;
    logic [C_NUM_REQ-1:0]         REQ_BYPASS;
    logic                         OUT_VALID;
    logic                         OUT_READY;
    logic [C_WIDTH:0]             OUT_S;
    logic [C_ID_WIDTH-1:0]        OUT_ID;
    logic                         BUSY;

    modport master (
        output REQ_VALID, REQ_A, REQ_BYPASS, OUT_READY,
        input  REQ_READY, OUT_VALID, OUT_S, OUT_ID, BUSY
    );

    modport slave (
        input  REQ_VALID, REQ_A, REQ_BYPASS, OUT_READY,
        output REQ_READY, OUT_VALID, OUT_S, OUT_ID, BUSY
    );
endinterface

// File: rtl/twos_comp_share_ctrl.sv
// ---------------------------------------------------------------------------
// twos_comp_share_ctrl
// Round-robin scheduler in front of one pipelined two's-complement negator.
// One operand per cycle is granted, negated (or sign-extended on bypass),
// tagged with the requester index and carried through C_PIPE_STAGES
// registers to a single valid/ready result port.
// Ports:
//   CLK    : clock, rising edge
//   ACLR_N : asynchronous active-low clear
//   FLUSH  : synchronous clear of all stage valid bits
//   bus    : twos_comp_share_ctrl_if.slave (request + result handshakes)
// ---------------------------------------------------------------------------

// Shared arithmetic: sign-extend to C_WIDTH+1 bits so the most negative
// input negates without overflow.
module twos_comp_share_ctrl_neg #(
    parameter int C_WIDTH = 16
) (
    input  logic [C_WIDTH-1:0] a,
    input  logic               bypass,
    output logic [C_WIDTH:0]   s
);
    localparam logic [C_WIDTH:0] ONE = {{C_WIDTH{1'b0}}, 1'b1};

    logic [C_WIDTH:0] ext;

    assign ext = {a[C_WIDTH-1], a};
    assign s   = bypass ? ext : (~ext + ONE);
endmodule

module twos_comp_share_ctrl #(
    parameter int C_WIDTH       = 16,
    parameter int C_NUM_REQ     = 4,
    parameter int C_ID_WIDTH    = 2,
    parameter int C_PIPE_STAGES = 2
) (
    input  logic                    CLK,
    input  logic                    ACLR_N,
    input  logic                    FLUSH,
    twos_comp_share_ctrl_if.slave   bus
);
    localparam logic [C_ID_WIDTH-1:0] ID_LAST = C_ID_WIDTH'(C_NUM_REQ - 1);
    localparam logic [C_ID_WIDTH-1:0] ID_ONE  = {{(C_ID_WIDTH-1){1'b0}}, 1'b1};

    // Stage 1 is the issue register, stage C_PIPE_STAGES drives the output.
    logic [C_PIPE_STAGES:1] vld_pipe;
    logic [C_WIDTH:0]       s_pipe  [1:C_PIPE_STAGES];
    logic [C_ID_WIDTH-1:0]  id_pipe [1:C_PIPE_STAGES];

    logic [C_ID_WIDTH-1:0]  ptr;
    logic [C_ID_WIDTH-1:0]  ptr_nxt;
    logic [C_ID_WIDTH-1:0]  gnt_id;
    logic [C_NUM_REQ-1:0]   gnt_oh;
    logic                   gnt_found;
    logic [C_WIDTH-1:0]     gnt_a;
    logic                   gnt_byp;
    logic [C_WIDTH:0]       issue_s;
    logic [C_NUM_REQ-1:0]   rdy;
    logic                   advance;
    logic                   hs;

    // Whole pipeline moves as one; a stalled output freezes every stage.
    assign advance = !vld_pipe[C_PIPE_STAGES] || bus.OUT_READY;

    // Rotating priority from ptr: first scan ptr..N-1, then wrap to 0..ptr-1.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        gnt_oh    = '0;
        gnt_a     = '0;
        gnt_byp   = 1'b0;
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (!gnt_found && bus.REQ_VALID[i] && (i >= int'(ptr))) begin
                gnt_found = 1'b1;
                gnt_id    = C_ID_WIDTH'(i);
                gnt_oh[i] = 1'b1;
                gnt_a     = bus.REQ_A[i*C_WIDTH +: C_WIDTH];
                gnt_byp   = bus.REQ_BYPASS[i];
            end
        end
        for (int i = 0; i < C_NUM_REQ; i++) begin
            if (!gnt_found && bus.REQ_VALID[i] && (i < int'(ptr))) begin
                gnt_found = 1'b1;
                gnt_id    = C_ID_WIDTH'(i);
                gnt_oh[i] = 1'b1;
                gnt_a     = bus.REQ_A[i*C_WIDTH +: C_WIDTH];
                gnt_byp   = bus.REQ_BYPASS[i];
            end
        end
    end

    // Ready is gated by reset so nothing looks accepted while clearing.
    assign rdy     = gnt_oh & {C_NUM_REQ{advance && !FLUSH && ACLR_N}};
    assign hs      = |rdy;
    assign ptr_nxt = (gnt_id == ID_LAST) ? '0 : (gnt_id + ID_ONE);

    twos_comp_share_ctrl_neg #(.C_WIDTH(C_WIDTH)) u_neg (
        .a      (gnt_a),
        .bypass (gnt_byp),
        .s      (issue_s)
    );

    always_ff @(posedge CLK or negedge ACLR_N) begin
        if (!ACLR_N) begin
            vld_pipe <= '0;
            ptr      <= '0;
            for (int i = 1; i <= C_PIPE_STAGES; i++) begin
                s_pipe[i]  <= '0;
                id_pipe[i] <= '0;
            end
        end else begin
            if (FLUSH) begin
                vld_pipe <= '0;
            end else if (advance) begin
                vld_pipe[1] <= hs;
                for (int i = 2; i <= C_PIPE_STAGES; i++)
                    vld_pipe[i] <= vld_pipe[i-1];
            end
            // Data only moves with a valid entry, so the output keeps its
            // last result when a bubble arrives.
            if (advance) begin
                if (hs) begin
                    s_pipe[1]  <= issue_s;
                    id_pipe[1] <= gnt_id;
                end
                for (int i = 2; i <= C_PIPE_STAGES; i++) begin
                    if (vld_pipe[i-1]) begin
                        s_pipe[i]  <= s_pipe[i-1];
                        id_pipe[i] <= id_pipe[i-1];
                    end
                end
            end
            if (hs)
                ptr <= ptr_nxt;
        end
    end

    assign bus.REQ_READY = rdy;
    assign bus.OUT_VALID = vld_pipe[C_PIPE_STAGES];
    assign bus.OUT_S     = s_pipe[C_PIPE_STAGES];
    assign bus.OUT_ID    = id_pipe[C_PIPE_STAGES];
    assign bus.BUSY      = |vld_pipe;
endmodule

// File: tb/tb_twos_comp_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_twos_comp_share_ctrl
// Directed scenarios plus randomized traffic against a queue-based model of
// a fixed-depth stalling pipeline fed by a rotating-priority arbiter.
// ---------------------------------------------------------------------------
module tb_twos_comp_share_ctrl;
    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int P   = 2;

    logic CLK = 1'b0;
    logic ACLR_N;
    logic FLUSH;

    twos_comp_share_ctrl_if #(.C_WIDTH(W), .C_NUM_REQ(N), .C_ID_WIDTH(IDW)) bus ();

    twos_comp_share_ctrl #(
        .C_WIDTH(W), .C_NUM_REQ(N), .C_ID_WIDTH(IDW), .C_PIPE_STAGES(P)
    ) dut (
        .CLK    (CLK),
        .ACLR_N (ACLR_N),
        .FLUSH  (FLUSH),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: run did not end, time=%0t", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit         v;
        logic [W:0] s;
        int         id;
    } ent_t;

    int         total = 0;
    int         bad   = 0;
    ent_t       pipe_q[$];   // index 0 = newest stage, last = output stage
    int         m_ptr;
    int         n_acc;
    int         n_cons;
    int         acc_ids[$];
    int         out_ids[$];
    logic [N-1:0] last_acc;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    // Result from integer arithmetic, truncated to W+1 bits.
    function automatic logic [W:0] m_res(input logic [W-1:0] a, input bit byp);
        int sa;
        int r;
        logic [31:0] rv;
        sa = int'($signed(a));
        r  = byp ? sa : -sa;
        rv = r;
        return rv[W:0];
    endfunction

    task automatic m_clear();
        ent_t e;
        e.v = 1'b0; e.s = '0; e.id = 0;
        pipe_q.delete();
        for (int i = 0; i < P; i++) pipe_q.push_back(e);
        m_ptr = 0;
    endtask

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_ptr + k) % N;
            if (bus.REQ_VALID[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: called just after a falling edge with inputs applied.
    task automatic cyc();
        int g;
        bit adv, ov, hs, busy;
        logic [N-1:0] er;
        ent_t ne, tail;
        #1;
        tail = pipe_q[P-1];
        ov   = tail.v;
        adv  = !ov || bus.OUT_READY;
        g    = m_grant();
        er   = '0;
        hs   = 1'b0;
        if (g >= 0 && adv && !FLUSH) begin
            er[g] = 1'b1;
            hs    = 1'b1;
        end
        busy = 1'b0;
        foreach (pipe_q[i]) busy |= pipe_q[i].v;
        chk("req_ready", 32'(bus.REQ_READY), 32'(er));
        chk("out_valid", 32'(bus.OUT_VALID), 32'(ov));
        if (ov) begin
            chk("out_s",  32'(bus.OUT_S),  32'(tail.s));
            chk("out_id", 32'(bus.OUT_ID), tail.id);
        end
        chk("busy", 32'(bus.BUSY), 32'(busy));
        ne.v  = hs;
        ne.id = hs ? g : 0;
        ne.s  = hs ? m_res(bus.REQ_A[g*W +: W], bus.REQ_BYPASS[g]) : '0;
        last_acc = er;
        if (hs) begin
            n_acc++;
            acc_ids.push_back(g);
            m_ptr = (g + 1) % N;
        end
        if (ov && bus.OUT_READY) begin
            n_cons++;
            out_ids.push_back(tail.id);
        end
        @(posedge CLK);
        if (adv) begin
            void'(pipe_q.pop_back());
            pipe_q.push_front(ne);
        end
        if (FLUSH) foreach (pipe_q[i]) pipe_q[i].v = 1'b0;
        @(negedge CLK);
    endtask

    task automatic drain();
        bus.REQ_VALID  = '0;
        bus.OUT_READY  = 1'b1;
        FLUSH          = 1'b0;
        repeat (P + 1) cyc();
    endtask

    task automatic send_one(input int id, input logic [W-1:0] a, input bit byp,
                            input logic [W:0] exp, input string tag);
        int n;
        bus.REQ_VALID          = '0;
        bus.REQ_VALID[id]      = 1'b1;
        bus.REQ_A[id*W +: W]   = a;
        bus.REQ_BYPASS[id]     = byp;
        bus.OUT_READY          = 1'b1;
        cyc();
        bus.REQ_VALID = '0;
        n = 0;
        while (!bus.OUT_VALID && n < 10) begin
            cyc();
            n++;
        end
        chk({tag, "_timeout"}, n < 10, 1);
        chk({tag, "_s"},  32'(bus.OUT_S),  32'(exp));
        chk({tag, "_id"}, 32'(bus.OUT_ID), id);
        cyc();
    endtask

    task automatic rand_reqs();
        logic [W-1:0] a;
        for (int i = 0; i < N; i++) begin
            if (!bus.REQ_VALID[i] || last_acc[i]) begin
                case ($urandom % 6)
                    0:       a = 16'h8000;
                    1:       a = 16'h0000;
                    2:       a = 16'hFFFF;
                    3:       a = 16'h7FFF;
                    default: a = W'($urandom);
                endcase
                bus.REQ_VALID[i]     = ($urandom % 100) < 60;
                bus.REQ_A[i*W +: W]  = a;
                bus.REQ_BYPASS[i]    = ($urandom % 4) == 0;
            end else if (($urandom % 100) < 5) begin
                bus.REQ_VALID[i] = 1'b0;
            end
        end
    endtask

    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        ACLR_N         = 1'b0;
        FLUSH          = 1'b0;
        bus.REQ_VALID  = '1;
        bus.REQ_A      = '0;
        bus.REQ_BYPASS = '0;
        bus.OUT_READY  = 1'b1;
        last_acc       = '0;
        n_acc          = 0;
        n_cons         = 0;
        m_clear();

        // Reset state, with requests pending to prove ready stays low.
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_req_ready", 32'(bus.REQ_READY), 0);
        chk("rst_out_valid", 32'(bus.OUT_VALID), 0);
        chk("rst_out_s",     32'(bus.OUT_S),     0);
        chk("rst_out_id",    32'(bus.OUT_ID),    0);
        chk("rst_busy",      32'(bus.BUSY),      0);
        @(negedge CLK);
        ACLR_N = 1'b1;

        // All requesters valid from reset: strict rotation.
        for (int i = 0; i < N; i++) bus.REQ_A[i*W +: W] = W'($urandom);
        acc_ids.delete();
        out_ids.delete();
        repeat (6) cyc();
        drain();
        chk("rr_n_grants", acc_ids.size(), 6);
        chk("rr_n_outs",   out_ids.size(), 6);
        for (int k = 0; k < 6; k++) begin
            if (k < acc_ids.size()) chk("rr_grant",  acc_ids[k], rr_exp[k]);
            if (k < out_ids.size()) chk("rr_out_id", out_ids[k], rr_exp[k]);
        end

        // Single request from requester 1.
        bus.REQ_VALID       = 4'b0010;
        bus.REQ_A[1*W +: W] = 16'h0005;
        bus.REQ_BYPASS[1]   = 1'b0;
        #1 chk("single_ready", 32'(bus.REQ_READY), 32'h2);
        cyc();
        bus.REQ_VALID = '0;
        cyc();
        #1;
        chk("single_valid", 32'(bus.OUT_VALID), 1);
        chk("single_s",     32'(bus.OUT_S),     32'h1FFFB);
        chk("single_id",    32'(bus.OUT_ID),    1);
        cyc();

        // Boundary operands.
        send_one(0, 16'h8000, 1'b0, 17'h08000, "neg_min");
        send_one(2, 16'h0000, 1'b0, 17'h00000, "neg_zero");
        send_one(3, 16'hFFFF, 1'b1, 17'h1FFFF, "byp_ffff");
        send_one(1, 16'h7FFF, 1'b0, 17'h18001, "neg_max");

        // Backpressure: fill, stall 5 cycles, release and drain.
        for (int i = 0; i < N; i++) bus.REQ_A[i*W +: W] = W'($urandom);
        bus.REQ_VALID = '1;
        repeat (3) cyc();
        bus.OUT_READY = 1'b0;
        repeat (5) begin
            #1 chk("bp_req_ready", 32'(bus.REQ_READY), 0);
            cyc();
        end
        drain();
        chk("bp_no_loss", n_cons, n_acc);

        // Asynchronous reset with two entries in flight.
        bus.REQ_VALID = '1;
        repeat (2) cyc();
        #3;
        ACLR_N = 1'b0;
        #1;
        chk("arst_out_valid", 32'(bus.OUT_VALID), 0);
        chk("arst_busy",      32'(bus.BUSY),      0);
        chk("arst_req_ready", 32'(bus.REQ_READY), 0);
        m_clear();
        n_acc  = 0;
        n_cons = 0;
        @(negedge CLK);
        @(negedge CLK);
        ACLR_N = 1'b1;
        #1 chk("arst_first_grant", 32'(bus.REQ_READY), 32'h1);
        cyc();
        drain();

        // FLUSH with two entries in flight.
        bus.REQ_VALID = '1;
        repeat (2) cyc();
        FLUSH = 1'b1;
        cyc();
        FLUSH = 1'b0;
        bus.REQ_VALID = '0;
        #1;
        chk("flush_busy",      32'(bus.BUSY),      0);
        chk("flush_out_valid", 32'(bus.OUT_VALID), 0);
        repeat (3) cyc();
        send_one(2, 16'h1234, 1'b0, 17'h1EDCC, "post_flush");

        // Randomized traffic with stalls and occasional flushes.
        n_acc  = 0;
        n_cons = 0;
        repeat (500) begin
            rand_reqs();
            bus.OUT_READY = ($urandom % 100) < 70;
            FLUSH         = ($urandom % 100) < 3;
            cyc();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/twos_comp_share_ctrl.md
Name: twos_comp_share_ctrl

Overview:
- Round-robin scheduler that shares one pipelined two's-complement negation datapath between C_NUM_REQ requesters.
- Each requester presents an operand with a valid/ready handshake and an optional bypass.
- The block arbitrates, issues one operand per cycle into a C_PIPE_STAGES-deep negate pipeline, and tags each result with the issuing requester ID.
- Results leave through a single valid/ready output port with full-pipeline backpressure. The block sits between the symbol-processing clients and the output result bus.

Parameters:
- C_WIDTH, 16, operand width; results are C_WIDTH+1 bits.
- C_NUM_REQ, 4, number of requesters (2..8).
- C_ID_WIDTH, 2, requester ID width; 2**C_ID_WIDTH must be >= C_NUM_REQ.
- C_PIPE_STAGES, 2, issue-to-output latency in cycles (1..8).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- ACLR_N  in  1  reset, asynchronous, active-low.
- FLUSH  in  1  synchronous clear of all pipeline valid bits.
- REQ_VALID  in  C_NUM_REQ  per-requester operand valid.
- REQ_READY  out  C_NUM_REQ  per-requester accept; one-hot or zero.
- REQ_A  in  C_NUM_REQ*C_WIDTH  operands; requester i occupies bits [i*C_WIDTH +: C_WIDTH].
- REQ_BYPASS  in  C_NUM_REQ  1 = pass operand sign-extended, 0 = negate.
- OUT_VALID  out  1  result valid.
- OUT_READY  in  1  downstream accept.
- OUT_S  out  C_WIDTH+1  result.
- OUT_ID  out  C_ID_WIDTH  requester index of the result.
- BUSY  out  1  any pipeline stage holds a valid entry.

Behaviour:
- Reset: CLK is the single clock; ACLR_N is asynchronous, active-low.
  - While ACLR_N=0, all stage valid bits clear and the RR pointer resets to 0.
  - REQ_READY=0, OUT_VALID=0, OUT_S=0, OUT_ID=0, BUSY=0.
  - A reset mid-operation discards all in-flight entries with no result emitted.
- Advance: advance = !OUT_VALID || OUT_READY.
  - When advance=1, every stage shifts forward one position.
  - When advance=0, all stages hold their data, valid bits and IDs unchanged.
- Arbitration: performed combinationally each cycle.
  - Search REQ_VALID starting at index ptr and wrap-around, picking the first set bit g.
  - REQ_READY[g] = advance && !FLUSH; all other REQ_READY bits are 0.
  - A handshake occurs when REQ_VALID[g] && REQ_READY[g]. On a handshake, ptr <= (g+1) mod C_NUM_REQ.
  - With no handshake, ptr holds.
- Request-side rules:
  - A requester must hold REQ_A and REQ_BYPASS stable while REQ_VALID=1 and not yet accepted.
  - Deasserting REQ_VALID before acceptance is permitted.
- Issue: stage 1 captures the result, the ID g and valid=handshake.
  - Stage 1 valid=0 when no request was issued in an advancing cycle, so bubbles propagate.
- Arithmetic: A is sign-extended to C_WIDTH+1 bits, giving ext.
  - Negate: S = (~ext + 1) mod 2**(C_WIDTH+1).
  - Bypass: S = ext.
  - The most negative input never overflows: 0x8000 gives +32768 = 17'h08000.
  - Zero negates to 0.
- Latency: for an operand accepted at edge t with no stall, OUT_VALID=1 after edge t+C_PIPE_STAGES-1.
  - C_PIPE_STAGES=1 gives the result in the cycle after acceptance.
  - Throughput is 1 result/cycle when OUT_READY=1.
- Output: OUT_S and OUT_ID come from the final stage.
  - While OUT_VALID=1 && OUT_READY=0, OUT_S and OUT_ID hold stable.
  - When OUT_VALID=0, OUT_S and OUT_ID keep their last values; they are not required to be zero.
- FLUSH=1: at the next edge, clear all valid bits; no handshake occurs in that cycle. Data registers may retain values.
- Simultaneous FLUSH and OUT_READY: the result present this cycle is consumed, then the pipeline is empty.
- Ordering: results emerge in issue order. Two requests from the same requester are never reordered.
- BUSY = OR of all stage valid bits, including the output stage.
- X-handling: REQ_VALID of X on the granted path drives OUT_VALID to X in simulation only; no X-masking is required.

Test Plan:
- Single request, C_PIPE_STAGES=2: requester 1 presents A=16'h0005 with bypass=0 and OUT_READY=1.
  - REQ_READY=4'b0010 for one cycle.
  - Two cycles after acceptance, OUT_VALID=1, OUT_S=17'h1FFFB, OUT_ID=1.
- Boundary values:
  - A=16'h8000 gives OUT_S=17'h08000.
  - A=16'h0000 gives 17'h00000.
  - A=16'hFFFF with bypass=1 gives 17'h1FFFF.
- All four requesters continuously valid from reset with OUT_READY=1: grant sequence is 0,1,2,3,0,1, and OUT_ID follows the same order one per cycle.
- Backpressure: fill the pipeline, then drop OUT_READY for 5 cycles.
  - OUT_S and OUT_ID stay stable and REQ_READY is all-zero.
  - On release, results drain in order with no loss or duplication.
- Reset mid-operation: assert ACLR_N=0 asynchronously with 2 entries in flight.
  - OUT_VALID and BUSY drop immediately.
  - After release, the first grant goes to requester 0.
- FLUSH with 2 entries in flight: the next cycle has BUSY=0 and OUT_VALID=0, no result emerges, and a subsequent request completes normally.
